// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between a fetch port and a data port, with a data-run limit and an access timeout.
module mem_arbiter #(
  parameter int MAX_D_RUN = 4,
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [63:0] i_addr,
  output logic [79:0] i_rdata,
  output logic        i_done,
  output logic        i_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [63:0] d_addr,
  input  logic [63:0] d_wdata,
  output logic [63:0] d_rdata,
  output logic        d_done,
  output logic        d_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic [79:0] mem_rdata,
  input  logic        mem_ack,
  output logic        busy
);
  localparam logic [1:0] IDLE = 2'd0, I_ACC = 2'd1, D_ACC = 2'd2;
  localparam int RW = $clog2(MAX_D_RUN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [1:0] r_state;
  logic [RW-1:0] r_run;
  logic [TW-1:0] r_to;
  logic [63:0] r_addr, r_wdata;
  logic r_we;
  logic w_grant_d, w_timeout, w_run_full;
  assign w_run_full = r_run == RW'(MAX_D_RUN);
  assign w_grant_d = d_req && !(i_req && w_run_full);
  // r_to counts completed no-ack cycles, so the TIMEOUT-th one ends the access
  assign w_timeout = !mem_ack && r_to == TW'(TIMEOUT - 1);
  assign busy = r_state != IDLE;
  assign mem_req = busy;
  assign mem_we = r_state == D_ACC && r_we;
  assign mem_addr = busy ? r_addr : '0;
  assign mem_wdata = r_state == D_ACC ? r_wdata : '0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_run <= '0;
      r_to <= '0;
      r_addr <= '0;
      r_wdata <= '0;
      r_we <= 1'b0;
      i_rdata <= '0;
      d_rdata <= '0;
      i_done <= 1'b0;
      i_err <= 1'b0;
      d_done <= 1'b0;
      d_err <= 1'b0;
    end else begin
      i_done <= 1'b0;
      i_err <= 1'b0;
      d_done <= 1'b0;
      d_err <= 1'b0;
      if (r_state == IDLE) begin
        r_to <= '0;
        if (w_grant_d) begin
          r_state <= D_ACC;
          r_addr <= d_addr;
          r_we <= d_we;
          r_wdata <= d_wdata;
          r_run <= w_run_full ? r_run : r_run + 1'b1;
        end else if (i_req) begin
          r_state <= I_ACC;
          r_addr <= i_addr;
          r_we <= 1'b0;
          r_run <= '0;
        end
      end else if (mem_ack || w_timeout) begin
        r_state <= IDLE;
        if (r_state == I_ACC) begin
          i_done <= 1'b1;
          i_err <= !mem_ack;
          i_rdata <= mem_ack ? mem_rdata : '0;
        end else begin
          d_done <= 1'b1;
          d_err <= !mem_ack;
          if (!mem_ack) d_rdata <= '0;
          else if (!r_we) d_rdata <= mem_rdata[79:16];
        end
      end else begin
        r_to <= r_to + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized traffic against a transaction-level model of the arbiter.
module tb_mem_arbiter;
  localparam int MAXR = 4, TO = 15;
  logic clk = 1'b0, rst = 1'b1;
  logic i_req = 1'b0, d_req = 1'b0, d_we = 1'b0, mem_ack = 1'b0;
  logic [63:0] i_addr = '0, d_addr = '0, d_wdata = '0;
  logic [79:0] mem_rdata = '0;
  logic [79:0] i_rdata;
  logic [63:0] d_rdata, mem_addr, mem_wdata;
  logic i_done, i_err, d_done, d_err, mem_req, mem_we, busy;
  mem_arbiter #(.MAX_D_RUN(MAXR), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata),
    .d_done(d_done), .d_err(d_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .busy(busy)
  );
  always #5 clk = ~clk;
  int errors = 0, checks = 0;
  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  // Model: which port owns the memory (0 none, 1 fetch, 2 data), how many data grants in a row, cycles waited
  int m_st = 0, m_run = 0, m_wait = 0;
  logic [63:0] m_addr = '0, m_wdata = '0, e_drdata = '0;
  logic m_we = 1'b0, e_idone = 1'b0, e_ierr = 1'b0, e_ddone = 1'b0, e_derr = 1'b0;
  logic [79:0] e_irdata = '0;
  string glog = "", dlog = "";
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_st = 0; m_run = 0; m_wait = 0; m_addr = '0; m_wdata = '0; m_we = 1'b0;
      e_irdata = '0; e_drdata = '0; e_idone = 1'b0; e_ierr = 1'b0; e_ddone = 1'b0; e_derr = 1'b0;
    end else begin
      e_idone = 1'b0; e_ierr = 1'b0; e_ddone = 1'b0; e_derr = 1'b0;
      if (m_st == 0) begin
        if (d_req && !(i_req && m_run == MAXR)) begin
          m_st = 2; m_wait = 0; m_addr = d_addr; m_we = d_we; m_wdata = d_wdata;
          m_run = m_run < MAXR ? m_run + 1 : MAXR;
          glog = {glog, "D"};
        end else if (i_req) begin
          m_st = 1; m_wait = 0; m_addr = i_addr; m_we = 1'b0; m_wdata = '0; m_run = 0;
          glog = {glog, "I"};
        end
      end else begin
        if (!mem_ack) m_wait++;
        if (mem_ack || m_wait == TO) begin
          if (m_st == 1) begin
            e_idone = 1'b1; e_ierr = !mem_ack; e_irdata = mem_ack ? mem_rdata : '0;
          end else begin
            e_ddone = 1'b1; e_derr = !mem_ack;
            if (!mem_ack) e_drdata = '0;
            else if (!m_we) e_drdata = mem_rdata[79:16];
          end
          m_st = 0;
        end
      end
    end
  end
  initial forever begin
    @(negedge clk);
    check("busy", 80'(busy), 80'(m_st != 0));
    check("mem_req", 80'(mem_req), 80'(m_st != 0));
    check("mem_we", 80'(mem_we), 80'(m_st == 2 && m_we));
    check("mem_addr", 80'(mem_addr), m_st != 0 ? 80'(m_addr) : 80'(0));
    if (m_st != 1) check("mem_wdata", 80'(mem_wdata), m_st == 2 ? 80'(m_wdata) : 80'(0));
    check("i_done", 80'(i_done), 80'(e_idone));
    check("i_err", 80'(i_err), 80'(e_ierr));
    check("d_done", 80'(d_done), 80'(e_ddone));
    check("d_err", 80'(d_err), 80'(e_derr));
    check("i_rdata", i_rdata, e_irdata);
    check("d_rdata", 80'(d_rdata), 80'(e_drdata));
  end
  task automatic cyc();
    @(negedge clk);
    if (d_done) dlog = {dlog, "D"};
    if (i_done) dlog = {dlog, "I"};
    #2;
  endtask
  int unsigned mode = 1;
  initial begin
    repeat (3) cyc();
    check("rst_busy", 80'(busy), 80'(0));
    check("rst_mem_addr", 80'(mem_addr), 80'(0));
    check("rst_i_rdata", i_rdata, 80'(0));
    rst = 1'b0;
    i_req = 1'b1; i_addr = 64'h100;
    cyc();
    check("f_mem_req", 80'(mem_req), 80'(1));
    check("f_mem_addr", 80'(mem_addr), 80'h100);
    check("f_mem_we", 80'(mem_we), 80'(0));
    cyc();
    mem_ack = 1'b1; mem_rdata = 80'h30F2_0A00_0000_0000_0000;
    cyc();
    check("f_i_done", 80'(i_done), 80'(1));
    check("f_i_err", 80'(i_err), 80'(0));
    check("f_i_rdata", i_rdata, 80'h30F2_0A00_0000_0000_0000);
    check("model_i_rdata", e_irdata, 80'h30F2_0A00_0000_0000_0000);
    i_req = 1'b0; mem_ack = 1'b0;
    cyc();
    check("f_i_done_pulse", 80'(i_done), 80'(0));
    d_req = 1'b1; d_we = 1'b1; d_addr = 64'h200; d_wdata = 64'hDEAD; i_req = 1'b1; i_addr = 64'h300;
    cyc();
    check("w_mem_we", 80'(mem_we), 80'(1));
    check("w_mem_addr", 80'(mem_addr), 80'h200);
    check("w_mem_wdata", 80'(mem_wdata), 80'hDEAD);
    mem_ack = 1'b1; mem_rdata = 80'h1111_2222_3333_4444_5555;
    cyc();
    check("w_d_done", 80'(d_done), 80'(1));
    check("w_d_rdata", 80'(d_rdata), 80'(0));
    d_req = 1'b0; d_we = 1'b0;
    cyc();
    check("w_then_i_addr", 80'(mem_addr), 80'h300);
    check("w_then_i_we", 80'(mem_we), 80'(0));
    cyc();
    check("w_then_i_done", 80'(i_done), 80'(1));
    d_req = 1'b1; mem_rdata = 80'hA5A5_5A5A_C3C3_3C3C_0F0F;
    dlog = ""; glog = "";
    repeat (20) cyc();
    d_req = 1'b0; i_req = 1'b0; mem_ack = 1'b0;
    checks++;
    if (dlog != "DDDDIDDDDI") begin errors++; $display("FAIL done_order: got %s expected DDDDIDDDDI", dlog); end
    checks++;
    if (glog != "DDDDIDDDDI") begin errors++; $display("FAIL model_grant_order: got %s expected DDDDIDDDDI", glog); end
    check("run_d_rdata", 80'(d_rdata), 80'h0000_A5A5_5A5A_C3C3_3C3C);
    d_req = 1'b1; d_addr = 64'h400;
    repeat (15) begin
      cyc();
      check("to_busy", 80'(busy), 80'(1));
      check("to_no_done", 80'(d_done), 80'(0));
    end
    cyc();
    check("to_d_done", 80'(d_done), 80'(1));
    check("to_d_err", 80'(d_err), 80'(1));
    check("to_d_rdata", 80'(d_rdata), 80'(0));
    check("to_idle", 80'(busy), 80'(0));
    d_req = 1'b0;
    cyc();
    check("to_err_pulse", 80'(d_err), 80'(0));
    d_req = 1'b1; d_addr = 64'h500;
    repeat (15) cyc();
    mem_ack = 1'b1; mem_rdata = 80'h0123_4567_89AB_CDEF_0246;
    cyc();
    check("edge_d_done", 80'(d_done), 80'(1));
    check("edge_d_err", 80'(d_err), 80'(0));
    check("edge_d_rdata", 80'(d_rdata), 80'h0123_4567_89AB_CDEF);
    mem_ack = 1'b0; d_addr = 64'h600;
    cyc();
    cyc();
    #1 rst = 1'b1;
    #1;
    check("ar_busy", 80'(busy), 80'(0));
    check("ar_mem_addr", 80'(mem_addr), 80'(0));
    check("ar_d_rdata", 80'(d_rdata), 80'(0));
    check("ar_i_rdata", i_rdata, 80'(0));
    cyc();
    cyc();
    check("ar_no_done", 80'(d_done), 80'(0));
    rst = 1'b0;
    cyc();
    check("ar_regrant", 80'(busy), 80'(1));
    check("ar_regrant_addr", 80'(mem_addr), 80'h600);
    mem_ack = 1'b1;
    cyc();
    check("ar_done", 80'(d_done), 80'(1));
    d_req = 1'b0; mem_ack = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (n % 64 == 0) mode = $urandom % 4;
      cyc();
      if (!i_req) begin
        if ($urandom % 2 == 0) begin i_req = 1'b1; i_addr = {$urandom, $urandom}; end
      end else if ((m_st == 1 && $urandom % 8 == 0) || (e_idone && $urandom % 2 == 0)) begin
        i_req = 1'b0;
      end
      if (m_st == 1) i_addr = {$urandom, $urandom};
      if (!d_req) begin
        if ($urandom % 2 == 0) begin
          d_req = 1'b1; d_we = 1'($urandom); d_addr = {$urandom, $urandom}; d_wdata = {$urandom, $urandom};
        end
      end else if ((m_st == 2 && $urandom % 8 == 0) || (e_ddone && $urandom % 2 == 0)) begin
        d_req = 1'b0;
      end
      if (m_st == 2) begin d_we = 1'($urandom); d_addr = {$urandom, $urandom}; d_wdata = {$urandom, $urandom}; end
      mem_ack = mode == 0 ? 1'b0 : ($urandom % 4 < mode);
      mem_rdata = {16'($urandom), $urandom, $urandom};
    end
    cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
